// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between two burst
// requesters; each grant runs a stepped sequence of consecutive register writes.
module regfile_write_arbiter #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req0,
  input  logic                       req1,
  input  logic [$clog2(NREGS)-1:0]   start0,
  input  logic [$clog2(NREGS)-1:0]   start1,
  input  logic [$clog2(NREGS)-1:0]   len0,
  input  logic [$clog2(NREGS)-1:0]   len1,
  input  logic                       dir0,
  input  logic                       dir1,
  input  logic [WIDTH-1:0]           data0,
  input  logic [WIDTH-1:0]           data1,
  output logic [$clog2(NREGS)-1:0]   regnum,
  output logic [WIDTH-1:0]           wr_data,
  output logic                       wr_enable,
  output logic                       ack0,
  output logic                       ack1,
  output logic                       done0,
  output logic                       done1
);
  localparam int IW = $clog2(NREGS);
  localparam logic [IW-1:0] ONE = IW'(1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          dir_q, dir_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] remain_q, remain_d;
  logic          winner;
  logic          burst;
  logic          last_beat;

  // On a tie the requester that did not win last time gets the port.
  assign winner = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    dir_d    = dir_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d  = BURST;
          owner_d  = winner;
          last_d   = winner;
          ptr_d    = winner ? start1 : start0;
          remain_d = winner ? len1 : len0;
          dir_d    = winner ? dir1 : dir0;
        end
      end
      BURST: begin
        if (remain_q == '0) begin
          state_d = IDLE;
        end else begin
          remain_d = remain_q - ONE;
          ptr_d    = dir_q ? ptr_q + ONE : ptr_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    burst     = (state_q == BURST);
    last_beat = burst && (remain_q == '0);
    wr_enable = burst;
    regnum    = burst ? ptr_q : '0;
    wr_data   = '0;
    if (burst) wr_data = owner_q ? data1 : data0;
    ack0      = burst && !owner_q;
    ack1      = burst && owner_q;
    done0     = last_beat && !owner_q;
    done1     = last_beat && owner_q;
  end

  // last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      dir_q    <= 1'b0;
      ptr_q    <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      dir_q    <= dir_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small register-file model
// sitting on the write port (register 0 discards writes).
module tb_regfile_write_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [4:0]  start0, start1, len0, len1;
  logic        dir0, dir1;
  logic [31:0] data0, data1;
  logic [4:0]  regnum;
  logic [31:0] wr_data;
  logic        wr_enable, ack0, ack1, done0, done1;

  logic [31:0] rf [32];
  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(.NREGS(32), .WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .start0(start0), .start1(start1),
    .len0(len0), .len1(len1),
    .dir0(dir0), .dir1(dir1),
    .data0(data0), .data1(data1),
    .regnum(regnum), .wr_data(wr_data), .wr_enable(wr_enable),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (wr_enable && regnum != 5'd0) rf[regnum] <= wr_data;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete burst by requester `who`; req is dropped and the burst
  // parameters scrambled right after grant to show they are not resampled.
  task automatic run_burst(input bit who, input logic [4:0] st, input logic [4:0] ln,
                           input logic dr, input logic [31:0] base);
    logic [4:0]  e;
    logic [31:0] d;
    if (!who) begin req0 = 1; start0 = st; len0 = ln; dir0 = dr; end
    else      begin req1 = 1; start1 = st; len1 = ln; dir1 = dr; end
    tick();
    req0 = 0; req1 = 0;
    start0 = ~st; start1 = ~st; len0 = 5'd31; len1 = 5'd31; dir0 = ~dr; dir1 = ~dr;
    for (int i = 0; i <= int'(ln); i++) begin
      d = base + 32'(i);
      if (!who) begin data0 = d; data1 = ~d; end
      else      begin data1 = d; data0 = ~d; end
      #1;
      e = dr ? st + 5'(i) : st - 5'(i);
      chk("burst_wen",    32'(wr_enable), 32'd1);
      chk("burst_regnum", 32'(regnum), 32'(e));
      chk("burst_wdata",  wr_data, d);
      chk("burst_ack",    {30'd0, ack1, ack0}, who ? 32'd2 : 32'd1);
      chk("burst_done",   {30'd0, done1, done0},
          (i == int'(ln)) ? (who ? 32'd2 : 32'd1) : 32'd0);
      tick();
    end
    chk("after_idle_wen",  32'(wr_enable), 32'd0);
    chk("after_idle_done", {30'd0, done1, done0}, 32'd0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    reset = 1; req0 = 0; req1 = 0;
    start0 = 0; start1 = 0; len0 = 0; len1 = 0; dir0 = 0; dir1 = 0;
    data0 = 0; data1 = 0;
    tick(); tick();
    chk("rst_wen",    32'(wr_enable), 32'd0);
    chk("rst_regnum", 32'(regnum), 32'd0);
    chk("rst_wdata",  wr_data, 32'd0);
    chk("rst_ack",    {30'd0, ack1, ack0}, 32'd0);
    chk("rst_done",   {30'd0, done1, done0}, 32'd0);
    reset = 0;

    // Decrementing burst 5,4,3,2.
    run_burst(1'b0, 5'd5, 5'd3, 1'b0, 32'hd00);
    chk("rf5", rf[5], 32'hd00);
    chk("rf4", rf[4], 32'hd01);
    chk("rf3", rf[3], 32'hd02);
    chk("rf2", rf[2], 32'hd03);
    chk("rf6", rf[6], 32'h0);
    chk("rf1_pre", rf[1], 32'h0);

    // Incrementing burst wrapping 30,31,0,1.
    run_burst(1'b1, 5'd30, 5'd3, 1'b1, 32'he00);
    chk("rf30", rf[30], 32'he00);
    chk("rf31", rf[31], 32'he01);
    chk("rf0",  rf[0],  32'h0);
    chk("rf1",  rf[1],  32'he03);

    // Single-beat burst.
    run_burst(1'b0, 5'd7, 5'd0, 1'b1, 32'h1234);
    chk("rf7", rf[7], 32'h1234);

    // Simultaneous requests held high: grants alternate 0,1,0,1 starting with 0.
    reset = 1; tick(); reset = 0;
    req0 = 1; req1 = 1;
    start0 = 5'd10; len0 = 5'd1; dir0 = 1;
    start1 = 5'd20; len1 = 5'd1; dir1 = 1;
    data0 = 32'ha0; data1 = 32'hb0;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("rr_ack",    {30'd0, ack1, ack0}, g[0] ? 32'd2 : 32'd1);
      chk("rr_regnum", 32'(regnum), g[0] ? 32'd20 : 32'd10);
      chk("rr_wdata",  wr_data, g[0] ? 32'hb0 : 32'ha0);
      tick();
      chk("rr_done",   {30'd0, done1, done0}, g[0] ? 32'd2 : 32'd1);
      chk("rr_regnum2", 32'(regnum), g[0] ? 32'd21 : 32'd11);
      tick();
      chk("rr_idle",   32'(wr_enable), 32'd0);
    end
    req0 = 0; req1 = 0;
    tick();

    // Reset during beat 2 of a 6-beat burst.
    reset = 1; tick(); reset = 0;
    req0 = 1; start0 = 5'd12; len0 = 5'd5; dir0 = 1; data0 = 32'hc0;
    tick();
    chk("abort_b1", 32'(regnum), 32'd12);
    tick();
    data0 = 32'hc1;
    #1;
    chk("abort_b2", 32'(regnum), 32'd13);
    chk("abort_b2_done", 32'(done0), 32'd0);
    reset = 1;
    tick();
    chk("abort_wen",  32'(wr_enable), 32'd0);
    chk("abort_done", {30'd0, done1, done0}, 32'd0);
    chk("abort_ack",  32'(ack0), 32'd0);
    reset = 0;
    chk("abort_rf12", rf[12], 32'hc0);
    chk("abort_rf13", rf[13], 32'hc1);
    chk("abort_rf14", rf[14], 32'h0);
    tick();
    chk("restart_regnum", 32'(regnum), 32'd12);
    chk("restart_ack",    32'(ack0), 32'd1);
    reset = 1; req0 = 0;
    tick();
    reset = 0;

    // Non-owner activity during owner 0's burst is ignored.
    req0 = 1; start0 = 5'd3; len0 = 5'd2; dir0 = 1;
    req1 = 0; start1 = 5'd25; len1 = 5'd0; dir1 = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      req1 = (i % 2 == 0);
      data1 = 32'hf0 + 32'(i);
      data0 = 32'h90 + 32'(i);
      #1;
      chk("own_regnum", 32'(regnum), 32'd3 + 32'(i));
      chk("own_wdata",  wr_data, 32'h90 + 32'(i));
      chk("own_ack",    {30'd0, ack1, ack0}, 32'd1);
      chk("own_done1",  32'(done1), 32'd0);
      if (i == 2) begin req0 = 0; req1 = 1; end
      tick();
    end
    chk("own_idle", 32'(wr_enable), 32'd0);
    tick();
    chk("next_ack",    {30'd0, ack1, ack0}, 32'd2);
    chk("next_regnum", 32'(regnum), 32'd25);
    chk("next_done",   32'(done1), 32'd1);
    req1 = 0;
    tick();
    chk("final_idle", 32'(wr_enable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port (regnum / data / write-enable) between two burst requesters. Each requester asks for a run of consecutive register writes (start register, length, direction). The arbiter grants one requester at a time with round-robin priority and steps the register number every cycle. It forwards the owner's data, acknowledges each beat, and flags burst completion. It sits directly in front of `regfile`'s write port and replaces a lone `reg_writer` when more than one agent must write.

## Interface
- `NREGS`, default 32: number of registers; fixed power of two, index width 5.
- `WIDTH`, default 32: data width.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0`, `req1`  in  1  burst request; held high until the matching `done` pulse.
- `start0`, `start1`  in  5  first register of the burst; sampled at grant.
- `len0`, `len1`  in  5  burst length minus 1 (0 = one write, 31 = 32 writes); sampled at grant.
- `dir0`, `dir1`  in  1  0 = decrement regnum per beat, 1 = increment; sampled at grant.
- `data0`, `data1`  in  WIDTH  write data for the current beat; must be valid in every cycle the matching `ack` is high.
- `regnum`  out  5  write register number to `regfile`.
- `wr_data`  out  WIDTH  write data to `regfile`.
- `wr_enable`  out  1  write enable to `regfile`.
- `ack0`, `ack1`  out  1  high in each cycle the requester's data is written at the next edge.
- `done0`, `done1`  out  1  one-cycle pulse coincident with the requester's last beat.

## Operation
- There are two states, IDLE and BURST. Other registers:
  - `owner` (1 bit)
  - `last` (1 bit, last granted requester)
  - `ptr` (5 bits)
  - `remain` (5 bits)
- On reset, the block enters IDLE with `last` = 1 (so `req0` wins the first tie) and `ptr` = `remain` = 0.
- IDLE:
  - If no request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both requests are high, grant the requester that is not `last`.
  - On grant: `owner` ← winner, `last` ← winner, `ptr` ← `start`, `remain` ← `len`, go to BURST.
- BURST, every cycle:
  - `wr_enable` = 1, `regnum` = `ptr`, `wr_data` = owner's data, owner's `ack` = 1.
  - If `remain` = 0, the owner's `done` = 1 and the next state is IDLE.
  - Otherwise `remain` ← `remain` − 1, and `ptr` ← `ptr` + 1 if `dir` = 1, or `ptr` − 1 if `dir` = 0.
- `ptr` arithmetic is modulo 32: 31 + 1 → 0 and 0 − 1 → 31.
  - Register 0 receives the write like any other register; `regfile` discards it.
- Outputs in IDLE are `wr_enable` = 0, `ack*` = 0, `done*` = 0, `regnum` = 0 and `wr_data` = 0.
- All outputs are combinational decodes of the state registers plus a data mux; there is no input-to-output path except `data*` → `wr_data`.
- The non-owner's `ack` and `done` stay 0 for the whole burst. Its request stays pending and is served in the next IDLE cycle.
- Dropping `req` mid-burst has no effect: the burst runs to completion.
- `start`, `len` and `dir` changing mid-burst have no effect; they are sampled only at grant.
- Reset asserted mid-burst:
  - The burst aborts and the next state is IDLE.
  - No `done` pulse is issued.
  - Write enable is 0 from the cycle after reset is sampled.

## Timing
- The grant decision is made at the edge where `req` is sampled high in IDLE; the first beat is presented in the next cycle.
  - Latency from `req` rising (set up before edge k) to first write: `wr_enable` high in cycle k+1, with the register written at edge k+2.
- A burst of length L occupies exactly L consecutive BURST cycles, followed by at least one IDLE cycle. The next grant happens at the end of that IDLE cycle.
- Back-to-back alternating bursts give a throughput of L writes per L+1 cycles.
- `done` is high in the same cycle as the final `ack` and `wr_enable`.
- A requester must deassert `req` or change its parameters in the cycle after `done`. If `req` is still high in the IDLE cycle, that is a new request.

## Test plan
- After reset, `req0` = 1 with `start0` = 5, `len0` = 3, `dir0` = 0 and data 0xd00..0xd03 one per cycle → registers 5, 4, 3, 2 hold 0xd00..0xd03. `done0` pulses with the 4th beat; registers 6 and 1 are unchanged.
- `req1` = 1 with `start1` = 30, `len1` = 3, `dir1` = 1 → writes go to 30, 31, 0, 1 (wrap-around). Register 1 gets the 4th datum and register 0 reads 0.
- `req0` and `req1` rise in the same cycle after reset → `req0` is granted first. After its `done0` and one IDLE cycle, `req1` is granted. With both re-requested, grants alternate 0, 1, 0, 1.
- `len0` = 0 single write with `start0` = 7, data 0x1234 → exactly one `wr_enable` cycle, with `ack0` and `done0` in that same cycle. Register 7 = 0x1234.
- Reset asserted during beat 2 of a 6-beat burst → `wr_enable` is 0 from the next cycle and no `done0` fires. Only beats 1 and 2 are visible in `regfile`; a fresh request afterwards restarts from `start0`.
- While owner 0 is bursting, `req1` toggles and `data1` changes → `regnum` and `wr_data` follow owner 0 only, `ack1` and `done1` stay 0, and `req1` is granted right after owner 0's IDLE cycle.
